tff_count_ctrl: RTL and testbench

TFF_COUNT_CTRL -- requirements
Module: tff_count_ctrl

---
 rtl/tff_pkg.sv | 12 +
 rtl/tff_bank.sv | 20 ++
 rtl/tff_count_ctrl.sv | 105 ++++++++++
 tb/tb_tff_count_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/tff_pkg.sv
// Shared types and defaults for the toggle-flip-flop count controller.
package tff_pkg;

    localparam int TFF_WIDTH_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } tff_state_t;

endpackage

// File: rtl/tff_bank.sv
// WIDTH-bit bank of toggle flip-flops: each bit flips where T is set.
module tff_bank #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] T,
    output logic [WIDTH-1:0] Q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_q <= '0;
        else     r_q <= r_q ^ T;
    end

    assign Q = r_q;

endmodule

// File: rtl/tff_count_ctrl.sv
// Command-driven counter built on a toggle bank; the FSM only chooses toggle vectors.
// Optional macro TFF_COUNT_CTRL_DOWN_EN adds a dir input for down counting.
module tff_count_ctrl
    import tff_pkg::*;
#(
    parameter int WIDTH = TFF_WIDTH_DEF
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    input  logic             load,
`ifdef TFF_COUNT_CTRL_DOWN_EN
    input  logic             dir,
`endif
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] term_val,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] T_out,
    output logic             busy,
    output logic             done
);

    tff_state_t       r_state, w_state_nxt;
    logic             r_done, w_done_nxt;
    logic [WIDTH-1:0] w_step, w_t;
    logic             w_down;

`ifdef TFF_COUNT_CTRL_DOWN_EN
    assign w_down = dir;
`else
    assign w_down = 1'b0;
`endif

    // Ripple-carry toggle pattern: bit i flips when all lower bits are 1 (up) or 0 (down).
    always_comb begin
        logic carry;
        carry  = 1'b1;
        w_step = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_step[i] = carry;
            carry     = carry & (w_down ? ~Q[i] : Q[i]);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        w_t         = '0;
        if (clear) begin
            w_t         = Q;
            w_state_nxt = IDLE;
        end else if (load) begin
            w_t         = Q ^ load_val;
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: if (start && !stop) w_state_nxt = RUN;
                RUN: begin
                    if (stop) begin
                        w_state_nxt = IDLE;
                    end else if (Q == term_val) begin
                        w_state_nxt = DONE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_t = w_step;
                    end
                end
                DONE: begin
                    if (stop) begin
                        w_state_nxt = IDLE;
                    end else if (start) begin
                        w_t         = Q;
                        w_state_nxt = RUN;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Commands seen during reset must not show up on the toggle vector.
    assign T_out = RST ? '0 : w_t;
    assign busy  = (r_state == RUN);
    assign done  = r_done;

    tff_bank #(.WIDTH(WIDTH)) u_bank (
        .CLK (CLK),
        .RST (RST),
        .T   (T_out),
        .Q   (Q)
    );

endmodule

// File: tb/tb_tff_count_ctrl.sv
// Directed bench for tff_count_ctrl with hand-computed expectations.
module tb_tff_count_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       start = 1'b0, stop = 1'b0, clear = 1'b0, load = 1'b0;
    logic [3:0] load_val = '0, term_val = '0;
    logic [3:0] Q, T_out;
    logic       busy, done;
`ifdef TFF_COUNT_CTRL_DOWN_EN
    logic       dir = 1'b0;
`endif

    int n_chk  = 0;
    int n_pass = 0;
    int n_done = 0;

    tff_count_ctrl #(.WIDTH(4)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .start    (start),
        .stop     (stop),
        .clear    (clear),
        .load     (load),
`ifdef TFF_COUNT_CTRL_DOWN_EN
        .dir      (dir),
`endif
        .load_val (load_val),
        .term_val (term_val),
        .Q        (Q),
        .T_out    (T_out),
        .busy     (busy),
        .done     (done)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        // reset state, with a load pending that must not leak onto T_out
        load = 1'b1; load_val = 4'hF;
        #2;
        chk("rst_q", Q, 0);
        chk("rst_t", T_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        tick();
        chk("rst_q_edge", Q, 0);
        load = 1'b0; RST = 1'b0;

        // count to terminal 5
        term_val = 4'd5; start = 1'b1;
        tick();
        start = 1'b0;
        chk("cnt_q0", Q, 0);
        chk("cnt_busy0", busy, 1);
        chk("cnt_t0", T_out, 1);
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("cnt_q", Q, k);
            chk("cnt_busy", busy, 1);
            chk("cnt_done", done, 0);
        end
        chk("cnt_t_term", T_out, 0);
        tick();
        chk("cnt_fin_q", Q, 5);
        chk("cnt_fin_done", done, 1);
        chk("cnt_fin_busy", busy, 0);
        tick();
        chk("cnt_hold_q", Q, 5);
        chk("cnt_pulse_end", done, 0);

        // restart from DONE clears to zero and runs
        start = 1'b1;
        #1 chk("done_start_t", T_out, 5);
        tick();
        start = 1'b0;
        chk("done_start_q", Q, 0);
        chk("done_start_busy", busy, 1);

        // load
        load = 1'b1; load_val = 4'b1010;
        tick();
        chk("ld1_q", Q, 4'b1010);
        load_val = 4'b0110;
        #1 chk("ld_t", T_out, 4'b1100);
        tick();
        load = 1'b0;
        chk("ld2_q", Q, 4'b0110);
        chk("ld2_busy", busy, 0);

        // wrap-around through all-ones
        term_val = 4'd2; load = 1'b1; load_val = 4'd14;
        tick();
        load = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("wr_q14", Q, 14);
        n_done = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("wr_q", Q, (15 + k) % 16);
            if (done) n_done++;
        end
        tick();
        chk("wr_done", done, 1);
        chk("wr_q_hold", Q, 2);
        chk("wr_no_early_done", n_done, 0);

        // priority: clear/load/stop together
        term_val = 4'd15; clear = 1'b1;
        tick();
        clear = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        chk("pr_q3", Q, 3);
        clear = 1'b1; load = 1'b1; load_val = 4'd9; stop = 1'b1;
        #1 chk("pr_t_clr", T_out, 3);
        tick();
        clear = 1'b0; load = 1'b0; stop = 1'b0;
        chk("pr_clr_q", Q, 0);
        chk("pr_clr_busy", busy, 0);

        // start and stop together: stop wins, Q held
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        chk("pr_q3b", Q, 3);
        start = 1'b1; stop = 1'b1;
        #1 chk("pr_ss_t", T_out, 0);
        tick();
        start = 1'b0; stop = 1'b0;
        chk("pr_ss_q", Q, 3);
        chk("pr_ss_busy", busy, 0);
        tick();
        chk("pr_ss_hold", Q, 3);

        // resume from held value
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("res_q", Q, 3);
        tick();
        chk("res_step", Q, 4);

        // asynchronous reset between edges while running at 7
        repeat (3) tick();
        chk("ar_q7", Q, 7);
        #2 RST = 1'b1;
        #1;
        chk("ar_q", Q, 0);
        chk("ar_busy", busy, 0);
        chk("ar_done", done, 0);
        chk("ar_t", T_out, 0);
        RST = 1'b0;
        tick();
        chk("ar_post_q", Q, 0);
        chk("ar_post_busy", busy, 0);

`ifdef TFF_COUNT_CTRL_DOWN_EN
        // down counting through zero
        dir = 1'b1; term_val = 4'd8; load = 1'b1; load_val = 4'd1;
        tick();
        load = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("dn_q1", Q, 1);
        tick();
        chk("dn_q0", Q, 0);
        chk("dn_t", T_out, 4'b1111);
        tick();
        chk("dn_q15", Q, 15);
        tick();
        chk("dn_q14", Q, 14);
        dir = 1'b0;
        tick();
        chk("dn_dirflip", Q, 15);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got 1 expected 0");
        $fatal(1);
    end

endmodule
